// File: rtl/delayed_trigger_pkg.sv
// Shared types and helpers for the multi-channel delayed trigger.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package delayed_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ARMED,
        FIRED
    } ch_state_t;

    localparam int MAX_W = 64;

    // reference - presamples - 1, floored at zero when presamples + 1 exceeds reference
    function automatic logic [MAX_W-1:0] clamp_threshold(
        input logic [MAX_W-1:0] ref_val,
        input logic [MAX_W-1:0] presamples
    );
        if (presamples >= ref_val) begin
            return '0;
        end
        return ref_val - presamples - 64'd1;
    endfunction

endpackage

// File: rtl/multi_channel_delayed_trigger_period_average.sv
// Moving average of the last 2**AVG_LOG2 pushed period lengths (circular buffer + running sum).
// Latency: average/valid update on the clock edge that accepts a push.
// Backpressure: none; a push is accepted every cycle it is asserted.
module period_average #(
    parameter int CW       = 32,
    parameter int AVG_LOG2 = 3
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          push,
    input  logic [CW-1:0] push_value,
    output logic [CW-1:0] average,
    output logic          valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = CW + AVG_LOG2;

    logic [CW-1:0]       history [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [SW-1:0]       sum;

    always_ff @(posedge clk) begin
        if (aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                history[i] <= '0;
            end
            wr_ptr <= '0;
            sum    <= '0;
            valid  <= 1'b0;
        end else if (push) begin
            // The slot being overwritten holds the oldest sample once the buffer has wrapped.
            history[wr_ptr] <= push_value;
            sum             <= sum + SW'(push_value) - SW'(history[wr_ptr]);
            wr_ptr          <= wr_ptr + 1'b1;
            if (&wr_ptr) begin
                valid <= 1'b1;
            end
        end
    end

    assign average = sum[SW-1 -: CW];

endmodule

// File: rtl/multi_channel_delayed_trigger.sv
// Period-locked trigger generator: NUM_CHANNELS channels fire a programmable number of samples before period end.
// Latency: trigger rises one cycle after the counter reaches the channel threshold.
// Backpressure: none; all inputs are sampled every cycle.
module multi_channel_delayed_trigger #(
    parameter int NUM_CHANNELS             = 4,
    parameter int TRIGGER_COUNTER_WIDTH    = 32,
    parameter int TRIGGER_PRESAMPLES_WIDTH = 32,
    parameter int AVG_LOG2                 = 3
) (
    input  logic                                               clk,
    input  logic                                               aresetn,
    input  logic                                               counter_reset,
    input  logic                                               use_average,
    input  logic [TRIGGER_COUNTER_WIDTH-1:0]                   reference_counter,
    input  logic [NUM_CHANNELS-1:0]                            trigger_arm,
    input  logic [NUM_CHANNELS-1:0]                            trigger_reset,
    input  logic [NUM_CHANNELS-1:0]                            continuous_mode,
    input  logic [NUM_CHANNELS*TRIGGER_PRESAMPLES_WIDTH-1:0]   trigger_presamples,
    output logic [NUM_CHANNELS-1:0]                            trigger,
    output logic [NUM_CHANNELS-1:0]                            trigger_armed,
    output logic [TRIGGER_COUNTER_WIDTH-1:0]                   last_counter,
    output logic [TRIGGER_COUNTER_WIDTH-1:0]                   average_counter,
    output logic                                               average_valid
);

    import delayed_trigger_pkg::*;

    localparam int CW = TRIGGER_COUNTER_WIDTH;
    localparam int PW = TRIGGER_PRESAMPLES_WIDTH;

    logic [CW-1:0] counter;
    logic          counter_reset_q;
    logic          period_end;
    logic          period_end_q;
    logic [CW-1:0] reference;

    assign period_end = counter_reset & ~counter_reset_q;

    // counter_reset_q resets high so a marker already high when reset lifts is not an edge
    always_ff @(posedge clk) begin
        if (aresetn) begin
            counter         <= '0;
            counter_reset_q <= 1'b1;
            period_end_q    <= 1'b0;
            last_counter    <= '0;
        end else begin
            counter_reset_q <= counter_reset;
            period_end_q    <= period_end;
            if (period_end) begin
                last_counter <= counter;
                counter      <= '0;
            end else if (!(&counter)) begin
                counter <= counter + 1'b1;
            end
        end
    end

    period_average #(
        .CW       (CW),
        .AVG_LOG2 (AVG_LOG2)
    ) u_period_average (
        .clk        (clk),
        .aresetn    (aresetn),
        .push       (period_end_q),
        .push_value (last_counter),
        .average    (average_counter),
        .valid      (average_valid)
    );

    assign reference = (use_average && average_valid) ? average_counter : reference_counter;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        ch_state_t     state_q;
        ch_state_t     state_d;
        logic          trig_q;
        logic          trig_d;
        logic [PW-1:0] presamples;
        logic [CW-1:0] threshold;
        logic          fire_cond;

        assign presamples = trigger_presamples[i*PW +: PW];
        assign threshold  = CW'(clamp_threshold(MAX_W'(reference), MAX_W'(presamples)));
        assign fire_cond  = (counter >= threshold);

        always_ff @(posedge clk) begin
            if (aresetn) begin
                state_q <= IDLE;
                trig_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                trig_q  <= trig_d;
            end
        end

        // A period end always takes precedence over firing in the same cycle.
        always_comb begin
            state_d = state_q;
            trig_d  = trig_q;
            if (trigger_reset[i]) begin
                state_d = IDLE;
                trig_d  = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (trigger_arm[i]) begin
                            state_d = PENDING;
                        end
                    end
                    PENDING: begin
                        if (!fire_cond || period_end) begin
                            state_d = ARMED;
                        end
                    end
                    ARMED: begin
                        if (fire_cond && !period_end) begin
                            state_d = FIRED;
                            trig_d  = 1'b1;
                        end
                    end
                    FIRED: begin
                        if (continuous_mode[i] && period_end) begin
                            state_d = ARMED;
                            trig_d  = 1'b0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        trig_d  = 1'b0;
                    end
                endcase
            end
        end

        assign trigger[i]       = trig_q;
        assign trigger_armed[i] = (state_q == ARMED) || (state_q == FIRED);
    end

endmodule

// File: tb/tb_multi_channel_delayed_trigger.sv
// Directed bench for multi_channel_delayed_trigger: one-shot, continuous, late arm, clamp, average and reset cases.
module tb_multi_channel_delayed_trigger;

    localparam int NC = 4;
    localparam int CW = 32;
    localparam int PW = 32;
    localparam int AL = 3;

    logic             clk;
    logic             aresetn;
    logic             counter_reset;
    logic             use_average;
    logic [CW-1:0]    reference_counter;
    logic [NC-1:0]    trigger_arm;
    logic [NC-1:0]    trigger_reset;
    logic [NC-1:0]    continuous_mode;
    logic [NC*PW-1:0] trigger_presamples;
    logic [NC-1:0]    trigger;
    logic [NC-1:0]    trigger_armed;
    logic [CW-1:0]    last_counter;
    logic [CW-1:0]    average_counter;
    logic             average_valid;

    int passed = 0;
    int total  = 0;
    int cnt    = 0;   // expected period counter value visible after the latest tick

    multi_channel_delayed_trigger #(
        .NUM_CHANNELS             (NC),
        .TRIGGER_COUNTER_WIDTH    (CW),
        .TRIGGER_PRESAMPLES_WIDTH (PW),
        .AVG_LOG2                 (AL)
    ) dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .counter_reset      (counter_reset),
        .use_average        (use_average),
        .reference_counter  (reference_counter),
        .trigger_arm        (trigger_arm),
        .trigger_reset      (trigger_reset),
        .continuous_mode    (continuous_mode),
        .trigger_presamples (trigger_presamples),
        .trigger            (trigger),
        .trigger_armed      (trigger_armed),
        .last_counter       (last_counter),
        .average_counter    (average_counter),
        .average_valid      (average_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cnt++;
    endtask

    task automatic tick_to(input int n);
        while (cnt < n) tick();
    endtask

    // Marker pulse: the edge is taken on the next clock, which clears the counter.
    task automatic pulse_end();
        counter_reset = 1'b1;
        tick();
        counter_reset = 1'b0;
        cnt = 0;
    endtask

    task automatic pulse_arm(input logic [NC-1:0] m);
        trigger_arm = m;
        tick();
        trigger_arm = '0;
    endtask

    task automatic pulse_clear(input logic [NC-1:0] m);
        trigger_reset = m;
        tick();
        trigger_reset = '0;
    endtask

    initial begin
        aresetn            = 1'b1;
        counter_reset      = 1'b0;
        use_average        = 1'b0;
        reference_counter  = 32'd1000;
        trigger_arm        = '0;
        trigger_reset      = '0;
        continuous_mode    = 4'b0010;
        trigger_presamples = {32'd0, 32'd5000, 32'd0, 32'd10};

        repeat (3) tick();
        check("rst_trigger", trigger, 0);
        check("rst_armed", trigger_armed, 0);
        check("rst_last", last_counter, 0);
        check("rst_avg", average_counter, 0);
        check("rst_valid", average_valid, 0);
        aresetn = 1'b0;
        cnt = 0;

        // ch0 one-shot, threshold 1000-10-1 = 989
        pulse_arm(4'b0001);
        check("ch0_pending", trigger_armed[0], 0);
        tick();
        check("ch0_armed", trigger_armed[0], 1);
        tick_to(989);
        check("ch0_before", trigger[0], 0);
        tick();
        check("ch0_rise", trigger[0], 1);
        tick_to(1000);
        pulse_end();
        check("last_1000", last_counter, 1000);
        check("ch0_hold", trigger[0], 1);
        tick_to(1000);
        pulse_end();
        check("ch0_hold2", trigger[0], 1);
        pulse_clear(4'b0001);
        check("ch0_clr_trig", trigger[0], 0);
        check("ch0_clr_armed", trigger_armed[0], 0);

        // ch1 continuous, threshold 999
        pulse_arm(4'b0010);
        for (int p = 0; p < 8; p++) begin
            tick_to(999);
            check("ch1_before", trigger[1], 0);
            tick();
            check("ch1_rise", trigger[1], 1);
            pulse_end();
            check("ch1_low_after_end", trigger[1], 0);
        end
        check("ch1_rearmed", trigger_armed[1], 1);
        // period end coincides with counter == threshold: no fire
        tick_to(999);
        check("ch1_coinc_before", trigger[1], 0);
        pulse_end();
        check("ch1_coinc_nofire", trigger[1], 0);
        check("last_999", last_counter, 999);
        tick_to(999);
        check("ch1_next_before", trigger[1], 0);
        tick();
        check("ch1_next_rise", trigger[1], 1);
        pulse_end();
        pulse_clear(4'b0010);
        check("ch1_clr", trigger[1], 0);

        // late arm on ch0: condition already true, waits for period end
        tick_to(995);
        pulse_arm(4'b0001);
        tick_to(1000);
        check("late_pending", trigger_armed[0], 0);
        check("late_no_trig", trigger[0], 0);
        pulse_end();
        check("late_armed", trigger_armed[0], 1);
        check("late_trig0", trigger[0], 0);
        tick_to(989);
        check("late_before", trigger[0], 0);
        tick();
        check("late_rise", trigger[0], 1);
        tick_to(1000);
        pulse_end();
        pulse_clear(4'b0001);

        // ch2 presamples 5000 > reference: threshold clamps to 0
        pulse_arm(4'b0100);
        tick_to(500);
        check("clamp_pending", trigger_armed[2], 0);
        check("clamp_no_trig", trigger[2], 0);
        tick_to(1000);
        pulse_end();
        check("clamp_armed", trigger_armed[2], 1);
        check("clamp_trig0", trigger[2], 0);
        tick();
        check("clamp_rise", trigger[2], 1);
        pulse_clear(4'b0100);

        // arm and trigger_reset together: reset wins
        trigger_arm   = 4'b0001;
        trigger_reset = 4'b0001;
        tick();
        trigger_arm   = '0;
        trigger_reset = '0;
        tick();
        tick();
        check("armrst_idle", trigger_armed[0], 0);
        pulse_arm(4'b1000);
        tick();
        check("ch3_armed", trigger_armed[3], 1);
        trigger_arm   = 4'b1000;
        trigger_reset = 4'b1000;
        tick();
        trigger_arm   = '0;
        trigger_reset = '0;
        check("armrst_ch3", trigger_armed[3], 0);
        tick();
        tick();
        check("armrst_ch3_stay", trigger_armed[3], 0);

        // fresh history: alternating 1000/1008 periods, average 1004 after the 8th
        aresetn = 1'b1;
        tick();
        aresetn = 1'b0;
        cnt = 0;
        check("avg_rst_valid", average_valid, 0);
        use_average = 1'b1;
        pulse_arm(4'b0001);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                tick_to(989);
                check("avg_ref_ext_before", trigger[0], 0);
                tick();
                check("avg_ref_ext_rise", trigger[0], 1);
            end
            tick_to((k % 2 == 0) ? 1000 : 1008);
            pulse_end();
            check("avg_valid_low", average_valid, 0);
        end
        tick();
        check("avg_valid_high", average_valid, 1);
        check("avg_value", average_counter, 1004);
        check("avg_last", last_counter, 1008);

        // average now drives the reference: threshold 1004-10-1 = 993
        pulse_clear(4'b0001);
        reference_counter = 32'd2000;
        pulse_arm(4'b0001);
        tick_to(993);
        check("avg_ref_before", trigger[0], 0);
        tick();
        check("avg_ref_rise", trigger[0], 1);

        // reset while FIRED
        aresetn = 1'b1;
        tick();
        check("midrst_trig", trigger, 0);
        check("midrst_armed", trigger_armed, 0);
        check("midrst_valid", average_valid, 0);
        check("midrst_avg", average_counter, 0);
        check("midrst_last", last_counter, 0);
        aresetn = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
